// File: rtl/usb_buffer_ptr_ctrl.sv
// Write/read pointer and occupancy controller for the USB packet buffer RAM.
// Produces same-cycle accept strobes, registered status flags and sticky error flags.
module usb_buffer_ptr_ctrl #(
  parameter int ADDR_W = 6,
  parameter int AF_TH  = (2 ** ADDR_W) - 4,
  parameter int AE_TH  = 4
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              clear,
  input  logic              push,
  input  logic              pop,
  input  logic              err_clr,
  output logic              wr_accept,
  output logic              rd_accept,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [ADDR_W-1:0] rd_ptr,
  output logic [ADDR_W:0]   occupancy,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow_err,
  output logic              underflow_err
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(2 ** ADDR_W);
  localparam logic [ADDR_W:0] AF_C    = (ADDR_W + 1)'(AF_TH);
  localparam logic [ADDR_W:0] AE_C    = (ADDR_W + 1)'(AE_TH);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   occ_q, occ_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              af_q, af_d;
  logic              ae_q, ae_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;

  // Handshake: push/pop are requests held by the protocol engines; wr_accept/
  // rd_accept are the same-cycle grants. A request without a grant is dropped
  // (and flagged), never retried internally. The RAM uses the current pointer
  // together with the grant at the same clock edge.
  always_comb begin
    rd_accept = pop & ~empty_q & ~clear;
    wr_accept = push & ~clear & (~full_q | rd_accept);
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(wr_accept);
      rd_ptr_d = rd_ptr_q + ADDR_W'(rd_accept);
      // Accept qualification keeps this within 0..DEPTH without saturation.
      occ_d    = occ_q + (ADDR_W + 1)'(wr_accept) - (ADDR_W + 1)'(rd_accept);
    end
  end

  // Flags derive from next occupancy so they line up with occupancy each cycle.
  always_comb begin
    full_d  = (occ_d == DEPTH_C);
    empty_d = (occ_d == '0);
    af_d    = (occ_d >= AF_C);
    ae_d    = (occ_d <= AE_C);
  end

  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (err_clr) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (push & ~wr_accept & ~clear) ovf_d = 1'b1;
    if (pop & ~rd_accept & ~clear)  udf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  assign wr_ptr        = wr_ptr_q;
  assign rd_ptr        = rd_ptr_q;
  assign occupancy     = occ_q;
  assign full          = full_q;
  assign empty         = empty_q;
  assign almost_full   = af_q;
  assign almost_empty  = ae_q;
  assign overflow_err  = ovf_q;
  assign underflow_err = udf_q;

endmodule

// File: tb/tb_usb_buffer_ptr_ctrl.sv
// Directed bench for usb_buffer_ptr_ctrl with an 8-entry buffer.
module tb_usb_buffer_ptr_ctrl;

  localparam int ADDR_W = 3;

  logic              clk;
  logic              n_rst;
  logic              clear, push, pop, err_clr;
  logic              wr_accept, rd_accept;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   occupancy;
  logic              full, empty, almost_full, almost_empty;
  logic              overflow_err, underflow_err;

  int n_checks;
  int n_errors;

  usb_buffer_ptr_ctrl #(.ADDR_W(ADDR_W), .AF_TH(6), .AE_TH(1)) dut (
    .clk(clk), .n_rst(n_rst), .clear(clear), .push(push), .pop(pop),
    .err_clr(err_clr), .wr_accept(wr_accept), .rd_accept(rd_accept),
    .wr_ptr(wr_ptr), .rd_ptr(rd_ptr), .occupancy(occupancy),
    .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .overflow_err(overflow_err),
    .underflow_err(underflow_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of requests, check grants before the edge.
  task automatic cycle(input logic p, input logic q, input logic c, input logic e,
                       input logic exp_wa, input logic exp_ra, input string tag);
    @(negedge clk);
    push = p; pop = q; clear = c; err_clr = e;
    #1;
    check({tag, ".wr_accept"}, 32'(wr_accept), 32'(exp_wa));
    check({tag, ".rd_accept"}, 32'(rd_accept), 32'(exp_ra));
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; clear = 1'b0; err_clr = 1'b0;
  endtask

  task automatic check_state(input string tag, input int wp, input int rp, input int occ,
                             input logic f, input logic em, input logic af, input logic ae,
                             input logic ovf, input logic udf);
    check({tag, ".wr_ptr"},    32'(wr_ptr),        32'(wp));
    check({tag, ".rd_ptr"},    32'(rd_ptr),        32'(rp));
    check({tag, ".occ"},       32'(occupancy),     32'(occ));
    check({tag, ".full"},      32'(full),          32'(f));
    check({tag, ".empty"},     32'(empty),         32'(em));
    check({tag, ".af"},        32'(almost_full),   32'(af));
    check({tag, ".ae"},        32'(almost_empty),  32'(ae));
    check({tag, ".ovf"},       32'(overflow_err),  32'(ovf));
    check({tag, ".udf"},       32'(underflow_err), 32'(udf));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    push = 1'b0; pop = 1'b0; clear = 1'b0; err_clr = 1'b0;
    n_rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    #1;
    check_state("reset", 0, 0, 0, 0, 1, 0, 1, 0, 0);

    // Fill: occupancy 1..8, flags at 2 / 6 / 8, wr_ptr wraps
    for (int i = 1; i <= 8; i++) begin
      cycle(1, 0, 0, 0, 1, 0, "fill");
      check_state($sformatf("fill%0d", i), i % 8, 0, i,
                  i == 8, 0, i >= 6, i <= 1, 0, 0);
    end
    cycle(1, 0, 0, 0, 0, 0, "push_full");
    check_state("push_full", 0, 0, 8, 1, 0, 1, 0, 1, 0);

    // Push+pop at full: both accepted, overflow stays from before
    cycle(1, 1, 0, 0, 1, 1, "pp_full");
    check_state("pp_full", 1, 1, 8, 1, 0, 1, 0, 1, 0);

    // Drain: rd_ptr 2..7,0,1
    for (int i = 1; i <= 8; i++) begin
      cycle(0, 1, 0, 0, 0, 1, "drain");
      check_state($sformatf("drain%0d", i), 1, (1 + i) % 8, 8 - i,
                  0, i == 8, (8 - i) >= 6, (8 - i) <= 1, 1, 0);
    end

    // Push+pop on empty: push accepted, pop rejected
    cycle(1, 1, 0, 0, 1, 0, "pp_empty");
    check_state("pp_empty", 2, 1, 1, 0, 0, 0, 1, 1, 1);

    cycle(0, 0, 0, 1, 0, 0, "err_clr");
    check_state("err_clr", 2, 1, 1, 0, 0, 0, 1, 0, 0);

    // Build to occupancy 5 then clear with push+pop
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0, 1, 0, "refill");
    check_state("refill", 6, 1, 5, 0, 0, 0, 0, 0, 0);
    cycle(1, 1, 1, 0, 0, 0, "clear");
    check_state("clear", 0, 0, 0, 0, 1, 0, 1, 0, 0);

    // Underflow set and err_clr together: set wins
    cycle(0, 1, 0, 1, 0, 0, "set_vs_clr");
    check_state("set_vs_clr", 0, 0, 0, 0, 1, 0, 1, 0, 1);
    cycle(0, 0, 0, 1, 0, 0, "clr2");
    check_state("clr2", 0, 0, 0, 0, 1, 0, 1, 0, 0);

    // Reset mid-fill: effect visible before any clock edge
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 1, 0, "pre_rst");
    check_state("pre_rst", 3, 0, 3, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 1, "pre_rst_pop");
    cycle(1, 0, 0, 0, 1, 0, "pre_rst_push");
    check_state("pre_rst2", 4, 1, 3, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    push = 1'b1;
    n_rst = 1'b0;
    #1;
    check_state("async_rst", 0, 0, 0, 0, 1, 0, 1, 0, 0);
    @(posedge clk);
    #1;
    check_state("rst_held", 0, 0, 0, 0, 1, 0, 1, 0, 0);
    push = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    cycle(1, 0, 0, 0, 1, 0, "post_rst");
    check_state("post_rst", 1, 0, 1, 0, 0, 0, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
